instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width and program counter width.
REQ-002 Parameter INSTR_W, default 6, instruction width, matching the decoder input.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  run enable; 1 = fetching permitted.
REQ-006 mem_rd  output  1  program-memory read strobe.
REQ-007 mem_addr  output  ADDR_W  program-memory read address.
REQ-008 mem_rdata  input  INSTR_W  read data, valid exactly one cycle after the mem_rd cycle.
REQ-009 instr  output  INSTR_W  registered instruction presented to the decoder.
REQ-010 instr_valid  output  1  instr holds a valid instruction.
REQ-011 instr_ready  input  1  decoder accepts instr this cycle.
REQ-012 jump_en  input  1  redirect the program counter on the accepting handshake.
REQ-013 jump_addr  input  ADDR_W  redirect target.
REQ-014 pc  output  ADDR_W  current program counter.
REQ-015 halted  output  1  HALT opcode fetched; fetch stopped.

Function
REQ-016 FSM states: IDLE, FETCH, WAIT, VALID, HALTED.
REQ-017 IDLE: en=1 -> FETCH next cycle; else stay.
REQ-018 FETCH: mem_rd=1 and mem_addr=pc for exactly one cycle -> WAIT.
REQ-019 WAIT: mem_rdata captured into instr at the closing edge; opcode HALT (all ones) -> HALTED; otherwise -> VALID.
REQ-020 VALID: instr_valid=1; instr stable until handshake (instr_valid & instr_ready).
REQ-021 Handshake with jump_en=1: pc <= jump_addr; otherwise pc <= pc+1, modulo 2^ADDR_W (all ones wraps to 0).
REQ-022 Handshake: en=1 -> FETCH; en=0 -> IDLE.
REQ-023 jump_en outside a handshake cycle is ignored; pc is unchanged.
REQ-024 en deasserted in FETCH or WAIT: the in-flight read completes and is presented normally; the new en value takes effect at the handshake.
REQ-025 HALTED: halted=1, instr_valid=0, mem_rd=0, pc frozen at the HALT address; exit only by reset.
REQ-026 HALT opcode is never presented with instr_valid=1.
REQ-027 mem_rd=0 in every state except FETCH; mem_addr equals pc in all states.
REQ-028 Best-case throughput is one instruction per 3 cycles (FETCH, WAIT, VALID with instr_ready=1).

Reset
REQ-029 While rst_n=0: state=IDLE, pc=0, instr=0, instr_valid=0, mem_rd=0, halted=0.
REQ-030 Reset asserted mid-operation discards any in-flight read and pending instruction; after release the first fetch is from address 0.

Structure
REQ-031 Shared package holds the state enum type and the opcode constant OP_HALT (6'b111111), shared with instruction_decoder.
REQ-032 One sub-module: program counter register, named instruction_fetch_pc, providing load and increment-with-wrap.

Verification
REQ-033 Reset, en=1, ROM[0..2]=000000,000001,001000, instr_ready=1 -> mem_rd at cycles 1,4,7; instr_valid cycles 3,6,9 with those values; pc 0->1->2->3.
REQ-034 instr_ready=0 for 5 cycles in VALID -> instr and instr_valid held, mem_rd=0, pc unchanged; ready=1 -> advance.
REQ-035 Handshake at pc=5 with jump_en=1, jump_addr=0x40 -> next mem_addr=0x40; jump_en pulsed in WAIT -> ignored, pc+1.
REQ-036 ROM[3]=111111 -> halted=1 two cycles after the pc=3 fetch, instr_valid stays 0, pc=3, no further mem_rd.
REQ-037 ADDR_W=8, pc=0xFF handshake -> next fetch address 0x00.
REQ-038 rst_n pulsed low during WAIT -> all outputs at reset values immediately; after release, the first fetch is from address 0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the instruction decoder.
//   if_state_e : fetch FSM state encoding
//   OP_HALT    : opcode that stops fetching (all ones)
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_VALID  = 3'd3,
        ST_HALTED = 3'd4
    } if_state_e;

    localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/instruction_fetch_pc.sv
// Program counter register for the fetch unit.
//   clk, rst_n  : clock, async active-low reset (pc clears to 0)
//   load_i      : load load_addr_i (has priority over inc_i)
//   load_addr_i : redirect target
//   inc_i       : increment by one, wrapping modulo 2^ADDR_W
//   pc_o        : current program counter
module instruction_fetch_pc #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            // Natural overflow of the ADDR_W-bit add gives the wrap to 0.
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads one instruction per program-memory access,
// holds it for the decoder until accepted, then advances or redirects the pc.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | fetching not enabled; waits for en
// FETCH   | mem_rd asserted for one cycle at mem_addr = pc
// WAIT    | read data arrives; captured into instr at the closing edge
// VALID   | instr_valid = 1 until the decoder handshake
// HALTED  | HALT opcode fetched; everything frozen until reset
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   en                  : run enable, sampled in IDLE and at the handshake
//   mem_rd, mem_addr    : program-memory read strobe and address (= pc)
//   mem_rdata           : read data, valid the cycle after mem_rd
//   instr, instr_valid  : registered instruction to the decoder
//   instr_ready         : decoder accepts instr
//   jump_en, jump_addr  : redirect applied only on the accepting handshake
//   pc                  : current program counter
//   halted              : HALT opcode fetched
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    localparam logic [INSTR_W-1:0] HALT_OP = INSTR_W'(OP_HALT);

    if_state_e          state_q;
    if_state_e          state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_d;
    logic               pc_load;
    logic               pc_inc;
    logic [ADDR_W-1:0]  pc_cur;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // en is deliberately not looked at: the read always completes.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                instr_d = mem_rdata;
                state_d = (mem_rdata == HALT_OP) ? ST_HALTED : ST_VALID;
            end
            ST_VALID: begin
                if (instr_ready) begin
                    pc_load = jump_en;
                    pc_inc  = !jump_en;
                    state_d = en ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    instruction_fetch_pc #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pc_load),
        .load_addr_i(jump_addr),
        .inc_i      (pc_inc),
        .pc_o       (pc_cur)
    );

    assign mem_rd      = (state_q == ST_FETCH);
    assign mem_addr    = pc_cur;
    assign pc          = pc_cur;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_VALID);
    assign halted      = (state_q == ST_HALTED);

endmodule
